// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch stage:
//   fetch_state_t  FSM encodings (FETCH_IDLE / FETCH_BUSY / FETCH_FLUSH)
//   fetch_entry_t  one instruction queue entry {addr, instr}
//   NOP            canonical RISC-V no-op (addi x0,x0,0)
//   WORD_STEP      byte distance between sequential fetch words
//   word_align()   clears the byte-offset bits of an address
// ---------------------------------------------------------------------------
package fetch_pkg;

   typedef enum logic [1:0] {
      FETCH_IDLE  = 2'd0,
      FETCH_BUSY  = 2'd1,
      FETCH_FLUSH = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam logic [31:0] WORD_STEP = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & 32'hFFFF_FFFC;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
// Small synchronous FIFO of {addr, instr} pairs between the memory port and
// decode. The head entry is visible combinationally so decode sees a word
// the cycle after it was pushed.
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   push, push_instr,      write one entry at the tail
//   push_addr
//   pop                    drop the head entry (caller guarantees count!=0)
//   flush                  empty the queue; overrides push and pop
//   count                  number of valid entries (0..QDEPTH)
//   head_instr, head_addr  oldest entry
// Push and pop in the same cycle are legal even when full: the write lands
// in the slot that the pop is vacating.
// ---------------------------------------------------------------------------
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int QDEPTH = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [31:0]                 push_instr,
   input  logic [31:0]                 push_addr,
   input  logic                        pop,
   input  logic                        flush,
   output logic [$clog2(QDEPTH+1)-1:0] count,
   output logic [31:0]                 head_instr,
   output logic [31:0]                 head_addr
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = $clog2(QDEPTH + 1);

   fetch_entry_t  entry_mem [QDEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [CW-1:0] count_reg;

   // Storage carries no reset: the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         entry_mem[wr_ptr_reg] <= '{addr: push_addr, instr: push_instr};
      end
   end

   // QDEPTH is a power of two, so the pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         count_reg <= count_reg + CW'(push) - CW'(pop);
      end
   end

   assign count      = count_reg;
   assign head_instr = entry_mem[rd_ptr_reg].instr;
   assign head_addr  = entry_mem[rd_ptr_reg].addr;

endmodule

// File: rtl/fetch.sv
// ---------------------------------------------------------------------------
// fetch
// Instruction fetch stage: issues sequential word reads on the instruction
// memory port, buffers returned words in fetch_queue and hands them to
// decode over valid/ready. A jmp pulse discards buffered words and any
// in-flight read, then restarts fetching at the redirect target.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   mem_addr, mem_rd      registered read request (held until mem_ack)
//   mem_rdata, mem_ack    read response, ack only honoured while mem_rd=1
//   jmp, jmp_addr         redirect pulse and target (bits [1:0] ignored)
//   instr, instr_addr     head-of-queue word and its address
//   valid, ready          decode handshake
// ---------------------------------------------------------------------------
module fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   input  logic        jmp,
   input  logic [31:0] jmp_addr,
   output logic [31:0] instr,
   output logic [31:0] instr_addr,
   output logic        valid,
   input  logic        ready
);

   localparam int CW = $clog2(QDEPTH + 1);
   localparam int OW = CW + 1;

   fetch_state_t  state_reg;
   logic [31:0]   pc_reg;
   logic          mem_rd_reg;
   logic [31:0]   mem_addr_reg;

   logic [CW-1:0] q_count;
   logic [31:0]   head_instr;
   logic [31:0]   head_addr;

   logic          ack;
   logic          push;
   logic          pop;
   logic [OW-1:0] occ_next;
   logic          credit;

   // An ack outside an active request (e.g. left over from before a reset)
   // is meaningless and must be ignored.
   assign ack   = mem_rd_reg && mem_ack;
   assign valid = (q_count != '0);
   assign pop   = valid && ready && !jmp;
   // Only a normal BUSY completion delivers data; FLUSH and jmp drop it.
   assign push  = ack && (state_reg == FETCH_BUSY) && !jmp;

   // Occupancy after this edge. A new read may start only if its word is
   // guaranteed a slot, which is what makes queue overflow impossible.
   assign occ_next = {1'b0, q_count} + OW'(push) - OW'(pop);
   assign credit   = (occ_next < OW'(QDEPTH));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= FETCH_IDLE;
         pc_reg       <= RESET_PC;
         mem_rd_reg   <= 1'b0;
         mem_addr_reg <= RESET_PC;
      end else if (jmp) begin
         pc_reg <= word_align(jmp_addr);
         unique case (state_reg)
            FETCH_IDLE: begin
               state_reg <= FETCH_IDLE;
            end
            FETCH_BUSY, FETCH_FLUSH: begin
               // Request completes now: drop it and restart from the new pc.
               // Otherwise keep mem_rd/mem_addr stable and wait it out.
               if (ack) begin
                  mem_rd_reg <= 1'b0;
                  state_reg  <= FETCH_IDLE;
               end else begin
                  state_reg  <= FETCH_FLUSH;
               end
            end
            default: begin
               mem_rd_reg <= 1'b0;
               state_reg  <= FETCH_IDLE;
            end
         endcase
      end else begin
         unique case (state_reg)
            FETCH_IDLE: begin
               if (credit) begin
                  mem_rd_reg   <= 1'b1;
                  mem_addr_reg <= pc_reg;
                  state_reg    <= FETCH_BUSY;
               end
            end
            FETCH_BUSY: begin
               if (ack) begin
                  pc_reg <= mem_addr_reg + WORD_STEP;
                  if (credit) begin
                     // Back-to-back: next word goes out immediately.
                     mem_addr_reg <= mem_addr_reg + WORD_STEP;
                  end else begin
                     mem_rd_reg <= 1'b0;
                     state_reg  <= FETCH_IDLE;
                  end
               end
            end
            FETCH_FLUSH: begin
               if (ack) begin
                  mem_rd_reg <= 1'b0;
                  state_reg  <= FETCH_IDLE;
               end
            end
            default: begin
               mem_rd_reg <= 1'b0;
               state_reg  <= FETCH_IDLE;
            end
         endcase
      end
   end

   fetch_queue #(
      .QDEPTH(QDEPTH)
   ) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_instr (mem_rdata),
      .push_addr  (mem_addr_reg),
      .pop        (pop),
      .flush      (jmp),
      .count      (q_count),
      .head_instr (head_instr),
      .head_addr  (head_addr)
   );

   assign mem_rd     = mem_rd_reg;
   assign mem_addr   = mem_addr_reg;
   // Drive a harmless no-op rather than stale queue contents when empty.
   assign instr      = valid ? head_instr : NOP;
   assign instr_addr = head_addr;

endmodule

// File: tb/tb_fetch.sv
// ---------------------------------------------------------------------------
// tb_fetch
// Directed bench for fetch. A wait-state memory model answers reads with
// rdata = addr ^ KEY. Each scenario pushes the addresses decode must see,
// in order, onto a scoreboard; a negedge monitor pops and compares on every
// accepted transfer and flags any transfer nobody expected.
// ---------------------------------------------------------------------------
module tb_fetch;
   import fetch_pkg::*;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int          QDEPTH   = 2;
   localparam logic [31:0] KEY      = 32'hA5A5_A5A5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic [31:0] mem_rdata = '0;
   logic        mem_ack = 1'b0;
   logic        jmp = 1'b0;
   logic [31:0] jmp_addr = '0;
   logic [31:0] instr;
   logic [31:0] instr_addr;
   logic        valid;
   logic        ready = 1'b0;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] sb [$];
   logic [31:0] exp_addr;
   int          mem_wait = 0;
   int          wcnt = 0;
   logic        stray_ack = 1'b0;

   always #5 clk = ~clk;

   fetch #(
      .RESET_PC(RESET_PC),
      .QDEPTH  (QDEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata),
      .mem_ack    (mem_ack),
      .jmp        (jmp),
      .jmp_addr   (jmp_addr),
      .instr      (instr),
      .instr_addr (instr_addr),
      .valid      (valid),
      .ready      (ready)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Memory: ack after mem_wait extra cycles; stray_ack fakes an ack while idle.
   always @(negedge clk) begin
      mem_rdata = mem_addr ^ KEY;
      if (mem_rd !== 1'b1) begin
         mem_ack = stray_ack;
         wcnt    = 0;
      end else begin
         mem_ack = (wcnt >= mem_wait);
         if (mem_ack) wcnt = 0;
         else         wcnt = wcnt + 1;
      end
   end

   // Decode-side monitor.
   always @(negedge clk) begin
      if (!rst) begin
         check("q_no_overflow", 32'(dut.u_queue.count_reg <= QDEPTH), 32'd1);
         if (valid && ready && !jmp) begin
            check("expected_word", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
               exp_addr = sb.pop_front();
               check("instr_addr", instr_addr, exp_addr);
               check("instr", instr, exp_addr ^ KEY);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int wait_states);
      rst       = 1'b1;
      jmp       = 1'b0;
      ready     = 1'b0;
      stray_ack = 1'b0;
      mem_wait  = wait_states;
      tick();
      tick();
      sb.delete();
      rst = 1'b0;
   endtask

   task automatic wait_req(input logic [31:0] a);
      int n = 0;
      while (!(mem_rd === 1'b1 && mem_addr === a) && n < 60) begin
         tick();
         n++;
      end
      check("req_seen", 32'(mem_rd === 1'b1 && mem_addr === a), 32'd1);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         tick();
         n++;
      end
      ready = 1'b0;
      check("drain_done", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      // 1: zero-wait streaming, one word per cycle
      do_reset(0);
      check("rst_mem_rd", 32'(mem_rd), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_mem_addr", mem_addr, RESET_PC);
      ready = 1'b1;
      for (int i = 0; i < 10; i++) sb.push_back(32'(4 * i));
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("t1_mem_rd", 32'(mem_rd), 32'd1);
         check("t1_mem_addr", mem_addr, 32'(4 * (k - 1)));
         check("t1_valid", 32'(valid), 32'(k >= 2));
         if (k >= 2) check("t1_head", instr_addr, 32'(4 * (k - 2)));
      end
      drain(40);

      // 2: decode stalled -> queue fills, fetch stops, then resumes
      do_reset(0);
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      sb.push_back(32'h8);
      tick();
      check("t2_c1_addr", mem_addr, 32'h0);
      tick();
      check("t2_c2_addr", mem_addr, 32'h4);
      check("t2_c2_valid", 32'(valid), 32'd1);
      tick();
      check("t2_stop_rd", 32'(mem_rd), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t2_hold_rd", 32'(mem_rd), 32'd0);
         check("t2_hold_addr", instr_addr, 32'h0);
         check("t2_hold_instr", instr, 32'h0 ^ KEY);
      end
      ready = 1'b1;
      tick();
      check("t2_resume_rd", 32'(mem_rd), 32'd1);
      check("t2_resume_addr", mem_addr, 32'h8);
      drain(20);

      // 3: redirect with a full queue; target low bits ignored
      do_reset(0);
      tick();
      tick();
      tick();
      jmp      = 1'b1;
      jmp_addr = 32'h103;
      ready    = 1'b1;
      sb.push_back(32'h100);
      tick();
      jmp = 1'b0;
      check("t3_valid_clr", 32'(valid), 32'd0);
      check("t3_rd_idle", 32'(mem_rd), 32'd0);
      tick();
      check("t3_rd", 32'(mem_rd), 32'd1);
      check("t3_addr", mem_addr, 32'h100);
      drain(20);

      // 4: redirect while a wait-stated read to 0x8 is pending
      do_reset(3);
      ready = 1'b1;
      sb.push_back(32'h0);
      wait_req(32'h8);
      jmp      = 1'b1;
      jmp_addr = 32'h200;
      sb.push_back(32'h200);
      tick();
      jmp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4_hold_rd", 32'(mem_rd), 32'd1);
         check("t4_hold_addr", mem_addr, 32'h8);
         check("t4_valid", 32'(valid), 32'd0);
         tick();
      end
      check("t4_rd_drop", 32'(mem_rd), 32'd0);
      tick();
      check("t4_new_rd", 32'(mem_rd), 32'd1);
      check("t4_new_addr", mem_addr, 32'h200);
      drain(40);

      // 5: redirect in the same cycle as the ack for 0xC
      do_reset(0);
      ready = 1'b1;
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      wait_req(32'hC);
      jmp      = 1'b1;
      jmp_addr = 32'h40;
      sb.push_back(32'h40);
      tick();
      jmp = 1'b0;
      check("t5_valid_clr", 32'(valid), 32'd0);
      check("t5_rd_idle", 32'(mem_rd), 32'd0);
      tick();
      check("t5_rd", 32'(mem_rd), 32'd1);
      check("t5_addr", mem_addr, 32'h40);
      drain(20);

      // 6: reset during a wait-stated read to 0x10, then a stray ack
      do_reset(3);
      ready = 1'b1;
      sb.push_back(32'h0);
      sb.push_back(32'h4);
      sb.push_back(32'h8);
      wait_req(32'h10);
      rst = 1'b1;
      tick();
      rst       = 1'b0;
      stray_ack = 1'b1;
      sb.delete();
      sb.push_back(RESET_PC);
      check("t6_rd_off", 32'(mem_rd), 32'd0);
      check("t6_valid", 32'(valid), 32'd0);
      tick();
      stray_ack = 1'b0;
      check("t6_refetch_rd", 32'(mem_rd), 32'd1);
      check("t6_refetch_addr", mem_addr, RESET_PC);
      check("t6_ack_ignored", 32'(valid), 32'd0);
      drain(40);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
